// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronizes/debounces the reset button, waits for PLL lock, stretches and drives sys_reset.
// Define RESET_SEQ_SOFT_RESET_EN to make soft_reset_req functional (reset_cause 10 becomes reachable).
module reset_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int STRETCH_CYCLES  = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ext_reset_req,
    input  logic       pll_locked,
    input  logic       soft_reset_req,
    output logic       sys_reset,
    output logic [1:0] reset_cause,
    output logic [1:0] seq_state
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(STRETCH_CYCLES + 1);

    typedef enum logic [1:0] {
        ASSERT    = 2'b00,
        WAIT_LOCK = 2'b01,
        STRETCH   = 2'b10,
        RUN       = 2'b11
    } state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] ext_ff, pll_ff;
    logic [DW-1:0]          db_cnt;
    logic [SW-1:0]          stretch_cnt, stretch_next;
    logic [1:0]             cause_next;
    logic                   ext_sync, pll_sync, ext_db;
    logic                   soft_pend, soft_hit;

    assign ext_sync  = ext_ff[SYNC_STAGES-1];
    assign pll_sync  = pll_ff[SYNC_STAGES-1];
    assign ext_db    = db_cnt == DW'(DEBOUNCE_CYCLES);
    assign seq_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            ext_ff <= '0;
            pll_ff <= '0;
            db_cnt <= '0;
        end else begin
            ext_ff <= {ext_ff[SYNC_STAGES-2:0], ext_reset_req};
            pll_ff <= {pll_ff[SYNC_STAGES-2:0], pll_locked};
            if (!ext_sync)
                db_cnt <= '0;
            else if (!ext_db)
                db_cnt <= db_cnt + 1'b1;
        end
    end

`ifdef RESET_SEQ_SOFT_RESET_EN
    // Pending holds ASSERT for one extra cycle after a software reset.
    assign soft_hit = soft_reset_req;
    always_ff @(posedge clock) begin
        if (reset)
            soft_pend <= 1'b0;
        else
            soft_pend <= (state == RUN) && soft_reset_req;
    end
`else
    logic unused_soft;
    assign unused_soft = soft_reset_req;
    assign soft_hit    = 1'b0;
    assign soft_pend   = 1'b0;
`endif

    always_comb begin
        state_next   = state;
        stretch_next = stretch_cnt;
        cause_next   = reset_cause;
        case (state)
            ASSERT: begin
                if (!ext_db && !soft_pend)
                    state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (ext_db) begin
                    state_next = ASSERT;
                end else if (pll_sync) begin
                    state_next   = STRETCH;
                    stretch_next = '0;
                end
            end
            STRETCH: begin
                if (ext_db) begin
                    state_next   = ASSERT;
                    stretch_next = '0;
                end else if (!pll_sync) begin
                    state_next   = WAIT_LOCK;
                    stretch_next = '0;
                end else if (stretch_cnt == SW'(STRETCH_CYCLES - 1)) begin
                    state_next   = RUN;
                    stretch_next = '0;
                end else begin
                    stretch_next = stretch_cnt + 1'b1;
                end
            end
            RUN: begin
                if (ext_db) begin
                    state_next = ASSERT;
                    cause_next = 2'b01;
                end else if (!pll_sync) begin
                    state_next = ASSERT;
                    cause_next = 2'b11;
                end else if (soft_hit) begin
                    state_next = ASSERT;
                    cause_next = 2'b10;
                end
            end
            default: state_next = ASSERT;
        endcase
    end

    // sys_reset is registered from the next state so it moves on the same edge as RUN entry/exit.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ASSERT;
            stretch_cnt <= '0;
            reset_cause <= 2'b00;
            sys_reset   <= 1'b1;
        end else begin
            state       <= state_next;
            stretch_cnt <= stretch_next;
            reset_cause <= cause_next;
            sys_reset   <= state_next != RUN;
        end
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized and directed checks of reset_sequencer against a cycle-level reference model.
module tb_reset_sequencer;
    localparam int SYNC = 2;
    localparam int DEB  = 8;
    localparam int STR  = 16;
    localparam logic [1:0] A = 2'd0, W = 2'd1, S = 2'd2, R = 2'd3;
`ifdef RESET_SEQ_SOFT_RESET_EN
    localparam bit SOFT_EN = 1'b1;
`else
    localparam bit SOFT_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ext_reset_req = 1'b0;
    logic       pll_locked = 1'b0;
    logic       soft_reset_req = 1'b0;
    logic       sys_reset;
    logic [1:0] reset_cause, seq_state;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    reset_sequencer #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .STRETCH_CYCLES(STR)) dut (
        .clock(clock),
        .reset(reset),
        .ext_reset_req(ext_reset_req),
        .pll_locked(pll_locked),
        .soft_reset_req(soft_reset_req),
        .sys_reset(sys_reset),
        .reset_cause(reset_cause),
        .seq_state(seq_state)
    );

    // Reference: inputs delayed through queues, button accepted after DEB consecutive highs,
    // stretch tracked as edges remaining before RUN.
    bit         ext_q[$], pll_q[$];
    int         run_len, rem;
    logic [1:0] m_state, m_cause;
    bit         m_pend, m_sysr;

    function automatic void model_reset();
        ext_q = {};
        pll_q = {};
        for (int i = 0; i < SYNC; i++) begin
            ext_q.push_back(1'b0);
            pll_q.push_back(1'b0);
        end
        run_len = 0;
        rem     = 0;
        m_state = A;
        m_cause = 2'd0;
        m_pend  = 1'b0;
        m_sysr  = 1'b1;
    endfunction

    function automatic void model_edge();
        bit db, ps, es, np;
        logic [1:0] nxt;
        if (reset) begin
            model_reset();
            return;
        end
        db  = run_len == DEB;
        ps  = pll_q[0];
        es  = ext_q[0];
        nxt = m_state;
        np  = SOFT_EN && m_state == R && soft_reset_req;
        case (m_state)
            A: if (!db && !m_pend) nxt = W;
            W: if (db) nxt = A; else if (ps) begin nxt = S; rem = STR; end
            S: if (db) nxt = A; else if (!ps) nxt = W; else begin rem--; if (rem == 0) nxt = R; end
            default: begin
                if (db) begin nxt = A; m_cause = 2'd1; end
                else if (!ps) begin nxt = A; m_cause = 2'd3; end
                else if (SOFT_EN && soft_reset_req) begin nxt = A; m_cause = 2'd2; end
            end
        endcase
        m_state = nxt;
        m_pend  = np;
        m_sysr  = nxt != R;
        void'(ext_q.pop_front());
        void'(pll_q.pop_front());
        ext_q.push_back(ext_reset_req);
        pll_q.push_back(pll_locked);
        run_len = es ? (run_len < DEB ? run_len + 1 : DEB) : 0;
    endfunction

    task automatic tick(input bit e, input bit p, input bit s, input bit r);
        ext_reset_req  = e;
        pll_locked     = p;
        soft_reset_req = s;
        reset          = r;
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic wait_run(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            n_cmp++;
            if ({sys_reset, reset_cause, seq_state} !== {m_sysr, m_cause, m_state}) begin
                n_fail++;
                $display("FAIL %s_model t=%0t got sr=%b c=%b st=%b want sr=%b c=%b st=%b", tag, $time,
                         sys_reset, reset_cause, seq_state, m_sysr, m_cause, m_state);
            end
            ok = seq_state === R;
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_reach_run got st=%b want st=%b", tag, seq_state, R);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b1);
        n_cmp += 3;
        if (seq_state !== A) begin n_fail++; $display("FAIL reset_state got %b want %b", seq_state, A); end
        if (sys_reset !== 1'b1) begin n_fail++; $display("FAIL reset_sysr got %b want 1", sys_reset); end
        if (reset_cause !== 2'd0) begin n_fail++; $display("FAIL reset_cause got %b want 00", reset_cause); end
    endtask

    task automatic test_power_on_latency();
        int fall = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            n_cmp++;
            if ({sys_reset, reset_cause, seq_state} !== {m_sysr, m_cause, m_state}) begin
                n_fail++;
                $display("FAIL por_model t=%0t got sr=%b c=%b st=%b want sr=%b c=%b st=%b", $time,
                         sys_reset, reset_cause, seq_state, m_sysr, m_cause, m_state);
            end
            if (fall == 0 && sys_reset === 1'b0) fall = i;
        end
        n_cmp += 3;
        if (fall != SYNC + 1 + STR) begin n_fail++; $display("FAIL por_latency got %0d want %0d", fall, SYNC + 1 + STR); end
        if (reset_cause !== 2'd0) begin n_fail++; $display("FAIL por_cause got %b want 00", reset_cause); end
        if (seq_state !== R) begin n_fail++; $display("FAIL por_state got %b want 11", seq_state); end
    endtask

    task automatic test_bounce();
        bit pat[$];
        int rise = 0;
        int fall = 0;
        for (int i = 0; i < 5; i++) pat.push_back(1'b1);
        for (int i = 0; i < 2; i++) pat.push_back(1'b0);
        for (int i = 0; i < 5; i++) pat.push_back(1'b1);
        for (int i = 0; i < 4; i++) pat.push_back(1'b0);
        foreach (pat[k]) begin
            tick(pat[k], 1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (sys_reset !== 1'b0 || {reset_cause, seq_state} !== {m_cause, m_state}) begin
                n_fail++;
                $display("FAIL bounce_quiet t=%0t got sr=%b st=%b want sr=0 st=%b", $time, sys_reset, seq_state, m_state);
            end
        end
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0);
            n_cmp++;
            if ({sys_reset, reset_cause, seq_state} !== {m_sysr, m_cause, m_state}) begin
                n_fail++;
                $display("FAIL bounce_model t=%0t got sr=%b c=%b st=%b want sr=%b c=%b st=%b", $time,
                         sys_reset, reset_cause, seq_state, m_sysr, m_cause, m_state);
            end
            if (rise == 0 && sys_reset === 1'b1) rise = i;
        end
        n_cmp += 2;
        if (rise != SYNC + DEB + 1) begin n_fail++; $display("FAIL bounce_rise got %0d want %0d", rise, SYNC + DEB + 1); end
        if (reset_cause !== 2'd1) begin n_fail++; $display("FAIL bounce_cause got %b want 01", reset_cause); end
        for (int i = 1; i <= 40 && fall == 0; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            if (sys_reset === 1'b0) fall = i;
        end
        n_cmp++;
        if (fall != SYNC + 3 + STR) begin n_fail++; $display("FAIL release_latency got %0d want %0d", fall, SYNC + 3 + STR); end
    endtask

    task automatic test_lock_loss();
        int rise = 0;
        int t0 = 0;
        int t1 = 0;
        bit hit = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            if (rise == 0 && sys_reset === 1'b1) rise = i;
        end
        n_cmp += 2;
        if (rise == 0 || rise > SYNC + 1) begin n_fail++; $display("FAIL lock_rise got %0d want 1..%0d", rise, SYNC + 1); end
        if (reset_cause !== 2'd3) begin n_fail++; $display("FAIL lock_cause got %b want 11", reset_cause); end
        for (int i = 0; i < 60 && !hit; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            hit = m_state == S && STR - rem == 5;
        end
        n_cmp++;
        if (seq_state !== S) begin n_fail++; $display("FAIL lock_mid_stretch got %b want 10", seq_state); end
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            hit = seq_state === W;
        end
        n_cmp++;
        if (!hit || m_state != W) begin n_fail++; $display("FAIL lock_restart got %b want 01", seq_state); end
        for (int i = 1; i <= 60 && t1 == 0; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            n_cmp++;
            if ({sys_reset, reset_cause, seq_state} !== {m_sysr, m_cause, m_state}) begin
                n_fail++;
                $display("FAIL relock_model t=%0t got sr=%b c=%b st=%b want sr=%b c=%b st=%b", $time,
                         sys_reset, reset_cause, seq_state, m_sysr, m_cause, m_state);
            end
            if (t0 == 0 && seq_state === S) t0 = i;
            if (seq_state === R) t1 = i;
        end
        n_cmp++;
        if (t0 == 0 || t1 - t0 != STR) begin n_fail++; $display("FAIL relock_stretch got %0d want %0d", t1 - t0, STR); end
    endtask

    task automatic test_soft();
        logic [1:0] prev = reset_cause;
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if ({sys_reset, reset_cause, seq_state} !== {m_sysr, m_cause, m_state}) begin
            n_fail++;
            $display("FAIL soft_model got sr=%b c=%b st=%b want sr=%b c=%b st=%b",
                     sys_reset, reset_cause, seq_state, m_sysr, m_cause, m_state);
        end
`ifdef RESET_SEQ_SOFT_RESET_EN
        n_cmp += 2;
        if (sys_reset !== 1'b1 || reset_cause !== 2'd2) begin
            n_fail++; $display("FAIL soft_assert got sr=%b c=%b want sr=1 c=10", sys_reset, reset_cause);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        if (seq_state !== A) begin n_fail++; $display("FAIL soft_hold got %b want 00", seq_state); end
        wait_run("soft");
`else
        n_cmp++;
        if (sys_reset !== 1'b0 || seq_state !== R || reset_cause !== prev) begin
            n_fail++; $display("FAIL soft_ignored got sr=%b st=%b c=%b want sr=0 st=11 c=%b", sys_reset, seq_state, reset_cause, prev);
        end
`endif
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_priority();
        for (int i = 1; i <= DEB + 3; i++) begin
            if (i == DEB + 3) begin
                n_cmp++;
                if (seq_state !== R) begin n_fail++; $display("FAIL prio_pre got %b want 11", seq_state); end
            end
            tick(1'b1, i < DEB + 1, i == DEB + 3, 1'b0);
        end
        n_cmp++;
        if (reset_cause !== 2'd1 || sys_reset !== 1'b1) begin
            n_fail++; $display("FAIL prio_cause got c=%b sr=%b want c=01 sr=1", reset_cause, sys_reset);
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        wait_run("prio");
    endtask

    task automatic test_reset_mid_stretch();
        bit hit = 1'b0;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 60 && !hit; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            hit = m_state == S && STR - rem == 7;
        end
        n_cmp++;
        if (seq_state !== S || reset_cause !== 2'd3) begin
            n_fail++; $display("FAIL midrst_setup got st=%b c=%b want st=10 c=11", seq_state, reset_cause);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (seq_state !== A || sys_reset !== 1'b1 || reset_cause !== 2'd0 || dut.stretch_cnt !== '0 || dut.db_cnt !== '0) begin
            n_fail++; $display("FAIL midrst_state got st=%b sr=%b c=%b want st=00 sr=1 c=00 counters 0", seq_state, sys_reset, reset_cause);
        end
        wait_run("midrst");
    endtask

    task automatic test_random();
        bit e = 1'b0;
        bit p = 1'b1;
        int hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                hold = $urandom_range(1, 30);
                e = $urandom_range(0, 4) == 0;
                p = $urandom_range(0, 4) != 0;
            end
            hold--;
            tick(e, p, $urandom_range(0, 15) == 0, $urandom_range(0, 250) == 0);
            n_cmp++;
            if ({sys_reset, reset_cause, seq_state} !== {m_sysr, m_cause, m_state}) begin
                n_fail++;
                $display("FAIL random_model t=%0t got sr=%b c=%b st=%b want sr=%b c=%b st=%b", $time,
                         sys_reset, reset_cause, seq_state, m_sysr, m_cause, m_state);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_power_on_latency();
        test_bounce();
        test_lock_loss();
        test_soft();
        test_priority();
        test_reset_mid_stretch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
